// File: rtl/sd_clk_edge_gate.sv
// -----------------------------------------------------------------------------
// sd_clk_edge_gate
//
// Edge-counting gate generator for the SD clock path. The slow external SD
// clock is synchronised into the CLOCK_50 domain, its selected edges are
// turned into single-cycle pulses, and those pulses are counted inside a
// window opened by start (count from 0) or resend (count from cfg_preload).
// gate_signal is high while the window is open. The window closes with a
// one-cycle done pulse when the count reaches the latched limit, or with a
// sticky timeout_err if no edge arrives for TO_CYCLES system clocks.
//
// Ports:
//   CLOCK_50     in   system clock, all logic on its rising edge
//   rst_n        in   synchronous active-low reset
//   sd_clk_in    in   asynchronous SD clock
//   start        in   pulse: open window with count = 0
//   resend       in   pulse: open window with count = cfg_preload
//   cfg_limit    in   count at which the window closes (sampled at open)
//   cfg_preload  in   resend load value (sampled at resend)
//   gate_signal  out  high while the window is open (COUNT state)
//   busy         out  high in COUNT state
//   done         out  one-cycle pulse when the limit is reached
//   timeout_err  out  sticky stall flag, cleared by start/resend/reset
//   edge_count   out  current edge count
//
// Parameter constraints: SYNC_STAGES >= 2, TO_CYCLES < 2**TO_W, TO_CYCLES >= 1.
// -----------------------------------------------------------------------------
module sd_clk_edge_gate #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_POL    = 1'b0,
    parameter int TO_W        = 10,
    parameter int TO_CYCLES   = 600
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             sd_clk_in,
    input  logic             start,
    input  logic             resend,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic [CNT_W-1:0] cfg_preload,
    output logic             gate_signal,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] edge_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Timeout fires on the cycle the stall counter would reach TO_CYCLES.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   sync_out;
    logic                   edge_pulse;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sd_clk_in};
        hist_d = sync_out;
    end

    // Combinational pulse off the last sync stage and the history flop; it is
    // consumed on the following clock edge, so edge_count moves SYNC_STAGES+1
    // cycles after the pin changes. hist follows sync every cycle, so the
    // pulse can never be high for two consecutive cycles.
    generate
        if (EDGE_POL == 1'b0) begin : g_rise
            assign edge_pulse = sync_out & ~hist_q;
        end else begin : g_fall
            assign edge_pulse = ~sync_out & hist_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Window FSM and counters
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             open_req;
    logic [CNT_W-1:0] open_count;
    logic [CNT_W:0]   count_inc;

    // start beats resend when both arrive together.
    assign open_req   = start | resend;
    assign open_count = start ? '0 : cfg_preload;

    // One extra bit so the increment can never alias onto a small limit.
    assign count_inc  = {1'b0, edge_count_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d      = state_q;
        edge_count_d = edge_count_q;
        limit_d      = limit_q;
        to_cnt_d     = to_cnt_q;
        done_d       = 1'b0;
        err_d        = err_q;

        if (open_req) begin
            // Open (or restart) the window from any state.
            state_d      = ST_COUNT;
            edge_count_d = open_count;
            limit_d      = cfg_limit;
            to_cnt_d     = '0;
            err_d        = 1'b0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (edge_count_q >= limit_q) begin
                        // Limit already satisfied at entry: the window stays
                        // open for exactly one cycle, then closes without
                        // counting.
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else if (edge_pulse) begin
                        edge_count_d = count_inc[CNT_W-1:0];
                        to_cnt_d     = '0;
                        if (count_inc == {1'b0, limit_q}) begin
                            state_d = ST_HOLD;
                            done_d  = 1'b1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        // Stalled SD clock: abandon the window, keep count.
                        state_d  = ST_IDLE;
                        err_d    = 1'b1;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            sync_q       <= '0;
            hist_q       <= 1'b0;
            state_q      <= ST_IDLE;
            edge_count_q <= '0;
            limit_q      <= '0;
            to_cnt_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            hist_q       <= hist_d;
            state_q      <= state_d;
            edge_count_q <= edge_count_d;
            limit_q      <= limit_d;
            to_cnt_q     <= to_cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // The gate is a pure function of state, so it drops in the same cycle
    // edge_count first shows the limit value.
    assign gate_signal = (state_q == ST_COUNT);
    assign busy        = (state_q == ST_COUNT);
    assign done        = done_q;
    assign timeout_err = err_q;
    assign edge_count  = edge_count_q;

endmodule
